// File: rtl/coincidence_pkg.sv
// Shared types and helpers for the coincidence-unit stimulus driver.
package coincidence_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] VEC_00 = 2'b00;
    localparam logic [1:0] VEC_01 = 2'b01;
    localparam logic [1:0] VEC_10 = 2'b10;
    localparam logic [1:0] VEC_11 = 2'b11;

    // vec[1] drives a, vec[0] drives b; the unit under test is an AND.
    function automatic logic exp_of(input logic [1:0] vec);
        return vec[1] & vec[0];
    endfunction

endpackage

// File: rtl/coincidence_stim_if.sv
// Stimulus/response link between the driver and the unit under test.
interface coincidence_stim_if;
    logic a;
    logic b;
    logic c;

    modport master (output a, output b, input c);
    modport slave  (input a, input b, output c);
endinterface

// File: rtl/err_accum.sv
// Saturating mismatch counter with capture of the first failing vector.
module err_accum #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample_en,
    input  logic             mismatch,
    input  logic [1:0]       vec,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       first_err_vec,
    output logic             first_err_valid
);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err_cnt         <= '0;
            first_err_vec   <= 2'b00;
            first_err_valid <= 1'b0;
        end else if (sample_en && mismatch) begin
            if (err_cnt != ERR_MAX)
                err_cnt <= err_cnt + ERR_W'(1);
            if (!first_err_valid) begin
                first_err_vec   <= vec;
                first_err_valid <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/coincidence_stim.sv
// Walks the four {a,b} vectors PASSES times, samples c after HOLD_CYCLES
// settle cycles and reports pass/fail, error count and first failing vector.
module coincidence_stim
    import coincidence_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int PASSES      = 4,
    parameter int ERR_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    coincidence_stim_if.master uut,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [1:0]         first_err_vec,
    output logic               first_err_valid
);
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASSES - 1);
    // With no settle time every vector goes straight to its sample cycle.
    localparam state_t ENTRY = (HOLD_CYCLES == 0) ? ST_SAMPLE : ST_DRIVE;

    state_t            state;
    logic [1:0]        vec;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PASS_W-1:0] pass_cnt;
    logic              mismatch;
    logic              sample_en;
    logic              clear;

    assign uut.a     = vec[1];
    assign uut.b     = vec[0];
    assign mismatch  = (uut.c != exp_of(vec));
    assign sample_en = (state == ST_SAMPLE);
    assign clear     = (state == ST_IDLE) && start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            vec      <= VEC_00;
            hold_cnt <= '0;
            pass_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ENTRY;
                        vec      <= VEC_00;
                        hold_cnt <= HOLD_LOAD;
                        pass_cnt <= '0;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    if (hold_cnt == '0)
                        state <= ST_SAMPLE;
                    else
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                end
                ST_SAMPLE: begin
                    if (vec == VEC_11 && pass_cnt == PASS_LAST) begin
                        state <= ST_DONE;
                        vec   <= VEC_00;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Fold in the final sample so pass is already valid during done.
                        pass  <= !first_err_valid && !mismatch;
                    end else begin
                        if (vec == VEC_11)
                            pass_cnt <= pass_cnt + PASS_W'(1);
                        vec      <= vec + 2'd1;
                        hold_cnt <= HOLD_LOAD;
                        state    <= ENTRY;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    err_accum #(.ERR_W(ERR_W)) u_err_accum (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (clear),
        .sample_en       (sample_en),
        .mismatch        (mismatch),
        .vec             (vec),
        .err_cnt         (err_cnt),
        .first_err_vec   (first_err_vec),
        .first_err_valid (first_err_valid)
    );
endmodule

// File: tb/tb_coincidence_stim.sv
// Three coincidence_stim configurations driven by fault-injecting responders,
// checked by a scoreboard against a per-run arithmetic model.
module tb_coincidence_stim;

    function automatic int h_of(input int i); return (i == 2) ? 0 : 2; endfunction
    function automatic int p_of(input int i); return (i == 2) ? 1 : 4; endfunction
    function automatic int w_of(input int i); return (i == 1) ? 2 : 8; endfunction

    typedef struct {
        int         inst;
        int         start_cyc;
        int         n;
        int         err;
        logic [1:0] fvec;
        logic       fev;
        logic       pass_e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       sb[$];

    logic [3:0] mask    [3];
    logic       start_v [3];
    logic       busy_a  [3];
    logic       done_a  [3];
    logic       pass_a  [3];
    logic       fev_a   [3];
    logic [1:0] fvec_a  [3];
    logic [1:0] ab_a    [3];
    logic [7:0] err_a   [3];
    int         done_cnt[3];
    logic       pass_chk[3];
    logic       pend_pass[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int H = h_of(gi);
        localparam int P = p_of(gi);
        localparam int W = w_of(gi);
        coincidence_stim_if uif();
        logic         busy, done, pass, fev;
        logic [W-1:0] err;
        logic [1:0]   fvec;

        // Responder: ideal AND, with the mask bit for the current vector flipping c.
        assign uif.c = (uif.a & uif.b) ^ mask[gi][{uif.a, uif.b}];

        coincidence_stim #(.HOLD_CYCLES(H), .PASSES(P), .ERR_W(W)) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .start           (start_v[gi]),
            .uut             (uif),
            .busy            (busy),
            .done            (done),
            .pass            (pass),
            .err_cnt         (err),
            .first_err_vec   (fvec),
            .first_err_valid (fev)
        );

        assign busy_a[gi] = busy;
        assign done_a[gi] = done;
        assign pass_a[gi] = pass;
        assign fev_a[gi]  = fev;
        assign fvec_a[gi] = fvec;
        assign err_a[gi]  = 8'(err);
        assign ab_a[gi]   = {uif.a, uif.b};
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever any instance pulses done.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (pass_chk[i]) begin
                check("pass_hold", int'(pass_a[i]), int'(pend_pass[i]));
                check("done_width", int'(done_a[i]), 0);
                pass_chk[i] = 1'b0;
            end
            if (done_a[i]) begin
                done_cnt[i]++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: inst %0d pulsed done with nothing pending", i);
                end else begin
                    e = sb.pop_front();
                    check("done_inst", i, e.inst);
                    check("done_latency", cyc - e.start_cyc, e.n);
                    check("busy_at_done", int'(busy_a[i]), 0);
                    check("ab_at_done", int'(ab_a[i]), 0);
                    check("err_cnt", int'(err_a[i]), e.err);
                    check("first_err_valid", int'(fev_a[i]), int'(e.fev));
                    if (e.fev) check("first_err_vec", int'(fvec_a[i]), int'(e.fvec));
                    check("pass_at_done", int'(pass_a[i]), int'(e.pass_e));
                    pass_chk[i]  = 1'b1;
                    pend_pass[i] = e.pass_e;
                end
            end
        end
    end

    task automatic check_reset(input int i);
        check("rst_busy", int'(busy_a[i]), 0);
        check("rst_done", int'(done_a[i]), 0);
        check("rst_pass", int'(pass_a[i]), 0);
        check("rst_err", int'(err_a[i]), 0);
        check("rst_fev", int'(fev_a[i]), 0);
        check("rst_fvec", int'(fvec_a[i]), 0);
        check("rst_ab", int'(ab_a[i]), 0);
    endtask

    // Pulses start for one cycle and pushes the modelled outcome.
    task automatic launch(input int i, input logic [3:0] m, input bit hold_start);
        exp_t e;
        int nerr, lim;
        mask[i] = m;
        @(negedge clk);
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold_start) start_v[i] = 1'b0;
        e.inst      = i;
        e.start_cyc = cyc;
        e.n         = p_of(i) * 4 * (h_of(i) + 1);
        nerr        = p_of(i) * $countones(m);
        lim         = (1 << w_of(i)) - 1;
        e.err       = (nerr > lim) ? lim : nerr;
        e.fev       = (m != 4'b0);
        e.fvec      = 2'b00;
        for (int v = 3; v >= 0; v--) if (m[v]) e.fvec = 2'(v);
        e.pass_e    = (m == 4'b0);
        sb.push_back(e);
        check("busy_after_start", int'(busy_a[i]), 1);
    endtask

    task automatic run(input int i, input logic [3:0] m);
        int d0, budget;
        d0 = done_cnt[i];
        launch(i, m, 1'b0);
        budget = p_of(i) * 4 * (h_of(i) + 1) + 20;
        while (done_cnt[i] == d0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: inst %0d never pulsed done", i);
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 3; i++) begin
            mask[i] = 4'b0; start_v[i] = 1'b0; done_cnt[i] = 0;
            pass_chk[i] = 1'b0; pend_pass[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check_reset(i);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check("idle_no_done", done_cnt[i], 0);

        // Defaults: ideal, stuck-at-0, random faults.
        run(0, 4'b0000);
        run(0, 4'b1000);
        for (int k = 0; k < 3; k++) run(0, 4'($urandom_range(1, 15)));

        // ERR_W=2: stuck-at-1 saturates, plus random faults.
        run(1, 4'b0111);
        for (int k = 0; k < 3; k++) run(1, 4'($urandom_range(1, 15)));
        run(1, 4'b0000);

        // HOLD=0, PASSES=1: one vector per cycle, start held through busy and done.
        d0 = done_cnt[2];
        launch(2, 4'b0000, 1'b1);
        for (int j = 0; j < 4; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            check("seq_ab", int'(ab_a[2]), j);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        start_v[2] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_restart", done_cnt[2] - d0, 1);
        check("idle_after_done", int'(busy_a[2]), 0);
        for (int k = 0; k < 2; k++) run(2, 4'($urandom_range(0, 15)));

        // Reset mid-run: vector 00 fails, sampled at cycles 2 and 14 before edge 20.
        d0 = done_cnt[0];
        launch(0, 4'b0001, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        check("pre_reset_err", int'(err_a[0]), 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset(0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt[0] - d0, 0);
        run(0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
